bcd_display_scheduler: RTL and testbench

//  Shares one sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) between two value sources.

---
 rtl/bcd_display_scheduler.sv | 126 ++++++++++++
 tb/tb_bcd_display_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scheduler.sv
// Round-robin scheduler sharing one serial shift-and-add-3 binary-to-BCD converter
// between two requesters; holds the last result (or a blank code on overflow).
module bcd_display_scheduler #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0,
  input  logic [WIDTH-1:0]      val0,
  input  logic                  req1,
  input  logic [WIDTH-1:0]      val1,
  output logic                  grant0,
  output logic                  grant1,
  output logic                  busy,
  output logic                  done,
  output logic                  valid,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   digits
);

  function automatic logic [63:0] calc_limit(input int d);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < d; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] LIMIT = calc_limit(DIGITS);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] SAT   = 2'd2;

  logic [1:0]          state;
  logic                last_grant;
  logic [CW-1:0]       cnt;
  logic [WIDTH-1:0]    val_r;
  logic [4*DIGITS-1:0] acc;
  logic [4*DIGITS-1:0] adj;
  logic [4*DIGITS-1:0] acc_next;
  logic [WIDTH-1:0]    sel_val;
  logic                pick1;
  logic                sel_over;
  logic [3:0]          nib;

  // Arbitration: source 1 wins when alone, or on a tie when source 0 went last.
  always_comb begin
    pick1    = req1 & (~req0 | ~last_grant);
    sel_val  = pick1 ? val1 : val0;
    sel_over = {{(64-WIDTH){1'b0}}, sel_val} > LIMIT;
    adj      = '0;
    nib      = '0;
    for (int n = 0; n < DIGITS; n++) begin
      nib = acc[4*n +: 4];
      adj[4*n +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
    acc_next = {adj[4*DIGITS-2:0], val_r[WIDTH-1]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
      grant0     <= 1'b0;
      grant1     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      valid      <= 1'b0;
      ovf        <= 1'b0;
      digits     <= '0;
    end else begin
      grant0 <= 1'b0;
      grant1 <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            grant0     <= ~pick1;
            grant1     <= pick1;
            last_grant <= pick1;
            busy       <= 1'b1;
            cnt        <= CNT_LAST;
            state      <= sel_over ? SAT : SHIFT;
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            digits <= acc_next;
            ovf    <= 1'b0;
            valid  <= 1'b1;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SAT: begin
          digits <= '1;
          ovf    <= 1'b1;
          valid  <= 1'b1;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath registers need no reset: IDLE always reloads them before use.
  always_ff @(posedge clock) begin
    if (state == IDLE) begin
      val_r <= sel_val;
      acc   <= '0;
    end else if (state == SHIFT) begin
      val_r <= val_r << 1;
      acc   <= acc_next;
    end
  end

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Scoreboard bench for bcd_display_scheduler: stimulus queues expected grants and
// results, a negedge monitor pops and compares them as the DUT presents them.
module tb_bcd_display_scheduler;
  localparam int WIDTH  = 32;
  localparam int DIGITS = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [31:0] val0 = '0;
  logic [31:0] val1 = '0;
  logic        grant0, grant1, busy, done, valid, ovf;
  logic [15:0] digits;

  bcd_display_scheduler #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .val0(val0), .req1(req1), .val1(val1),
    .grant0(grant0), .grant1(grant1), .busy(busy), .done(done),
    .valid(valid), .ovf(ovf), .digits(digits)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] d;
    logic        o;
    int          lat;
  } res_t;

  res_t        exp_res[$];
  int          exp_grant[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          grant_cyc = 0;
  int          done_cyc = 0;
  logic [15:0] held_d = '0;
  logic        held_o = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops expectations as grants and results appear.
  always @(negedge clock) begin
    int   s;
    res_t r;
    if (reset_n) begin
      if (grant0 | grant1) begin
        if (exp_grant.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_grant actual=%0d%0d required=none", grant1, grant0);
        end else begin
          s = exp_grant.pop_front();
          check("grant_src", {63'd0, grant1}, 64'(s));
          check("grant_onehot", {63'd0, grant0 & grant1}, 64'd0);
        end
        check("busy_at_grant", {63'd0, busy}, 64'd1);
        grant_cyc = cyc;
      end
      if (done) begin
        if (exp_res.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done actual=%0h required=none", digits);
        end else begin
          r = exp_res.pop_front();
          check("digits", {48'd0, digits}, {48'd0, r.d});
          check("ovf", {63'd0, ovf}, {63'd0, r.o});
          check("valid", {63'd0, valid}, 64'd1);
          check("latency", 64'(cyc - grant_cyc), 64'(r.lat));
        end
        check("busy_at_done", {63'd0, busy}, 64'd0);
        held_d   = digits;
        held_o   = ovf;
        done_cyc = cyc;
      end else if (busy && !(grant0 | grant1)) begin
        check("hold_digits", {48'd0, digits}, {48'd0, held_d});
        check("hold_ovf", {63'd0, ovf}, {63'd0, held_o});
      end
    end
  end

  task automatic expect_conv(input int src, input logic [15:0] d, input logic o, input int lat);
    res_t r;
    r.d = d; r.o = o; r.lat = lat;
    exp_grant.push_back(src);
    exp_res.push_back(r);
  endtask

  task automatic wait_grant(input int src);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock);
      if (src == 0 ? grant0 : grant1) got = 1'b1;
    end
    #1;
    if (!got) begin
      checks++; failures++;
      $display("FAIL grant_timeout src=%0d actual=none required=grant", src);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clock);
      #1;
      if (exp_res.size() == 0 && exp_grant.size() == 0 && !busy) ok = 1'b1;
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_res.size());
    end
  endtask

  task automatic issue(input int src, input logic [31:0] v, input logic [15:0] d,
                       input logic o, input int lat);
    expect_conv(src, d, o, lat);
    if (src == 0) begin val0 = v; req0 = 1'b1; end
    else          begin val1 = v; req1 = 1'b1; end
    wait_grant(src);
    if (src == 0) req0 = 1'b0; else req1 = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   {63'd0, busy},   64'd0);
    check({tag, "_grant"},  {62'd0, grant1, grant0}, 64'd0);
    check({tag, "_done"},   {63'd0, done},   64'd0);
    check({tag, "_valid"},  {63'd0, valid},  64'd0);
    check({tag, "_ovf"},    {63'd0, ovf},    64'd0);
    check({tag, "_digits"}, {48'd0, digits}, 64'd0);
  endtask

  task automatic async_reset_midrun(input string tag);
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    exp_res.delete();
    exp_grant.delete();
    held_d = '0;
    held_o = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clock);
    #1;
    check_reset_outputs("reset_init");
    @(negedge clock);
    reset_n = 1'b1;

    // Basic conversion.
    issue(0, 32'd1234, 16'h1234, 1'b0, WIDTH);
    drain();

    // Reset in the middle of a conversion, no clock edge needed.
    expect_conv(0, 16'h0777, 1'b0, WIDTH);
    val0 = 32'd777; req0 = 1'b1;
    wait_grant(0);
    req0 = 1'b0;
    repeat (5) @(negedge clock);
    async_reset_midrun("reset_mid");
    @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check("idle_after_reset", {63'd0, busy}, 64'd0);

    // Both requests held: round-robin starting with source 0.
    expect_conv(0, 16'h0042, 1'b0, WIDTH);
    expect_conv(1, 16'h9999, 1'b0, WIDTH);
    expect_conv(0, 16'h0042, 1'b0, WIDTH);
    val0 = 32'd42; val1 = 32'd9999; req0 = 1'b1; req1 = 1'b1;
    wait_grant(0);
    wait_grant(1);
    wait_grant(0);
    req0 = 1'b0; req1 = 1'b0;
    drain();

    // Overflow then largest in-range value.
    issue(1, 32'd10000, 16'hFFFF, 1'b1, 1);
    drain();
    issue(1, 32'd9999, 16'h9999, 1'b0, WIDTH);
    drain();

    // Zero, a request raised mid-conversion, then full-scale overflow.
    issue(0, 32'd0, 16'h0000, 1'b0, WIDTH);
    expect_conv(1, 16'h5678, 1'b0, WIDTH);
    repeat (6) @(negedge clock);
    val1 = 32'd5678; req1 = 1'b1;
    wait_grant(1);
    req1 = 1'b0;
    check("grant_gap_after_done", 64'(grant_cyc - done_cyc), 64'd1);
    drain();
    issue(0, 32'hFFFFFFFF, 16'hFFFF, 1'b1, 1);
    drain();

    // Reset pulse at SHIFT cycle 10 with req0 held: aborted, then regranted.
    expect_conv(0, 16'h4321, 1'b0, WIDTH);
    val0 = 32'd4321; req0 = 1'b1;
    wait_grant(0);
    repeat (9) @(negedge clock);
    async_reset_midrun("reset_shift10");
    expect_conv(0, 16'h4321, 1'b0, WIDTH);
    @(negedge clock);
    reset_n = 1'b1;
    wait_grant(0);
    req0 = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
